x_micro_recorder: RTL and testbench

Capture-side counterpart of the micro sequencer.
- Samples a 36-bit bus after a start pulse and run-length encodes it into the sequencer command format: DAT, DEL and END entries.
- Drives a sequencer-compatible RAM write port. A recorded waveform can then be replayed directly, or read back for inspection.

---
 rtl/x_micro_pkg.sv | 24 ++
 rtl/x_micro_rle_cnt.sv | 33 +++
 rtl/x_micro_recorder.sv | 172 +++++++++++++++++
 tb/tb_x_micro_recorder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_micro_pkg.sv
// Shared definitions for the micro sequencer and its capture-side recorder:
// command codes, field widths and the RAM entry layout.
package x_micro_pkg;

    localparam int MICRO_CMD_W = 4;
    localparam int MICRO_DW    = 36;
    localparam int MICRO_DELW  = 17;

    localparam logic [MICRO_CMD_W-1:0] CMD_DAT = 4'b0000;
    localparam logic [MICRO_CMD_W-1:0] CMD_DEL = 4'b0001;
    localparam logic [MICRO_CMD_W-1:0] CMD_END = 4'b0010;

    typedef struct packed {
        logic [MICRO_DW-1:0]    payload;
        logic [MICRO_CMD_W-1:0] cmd;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REC   = 2'd1,
        ST_FLUSH = 2'd2
    } rec_state_t;

endpackage

// File: rtl/x_micro_rle_cnt.sv
// Run-length counter for the recorder: clear has priority, counting stops at
// all-ones and o_tc flags that terminal count.
module x_micro_rle_cnt
    import x_micro_pkg::*;
#(
    parameter int DELW = MICRO_DELW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_inc,
    output logic [DELW-1:0] o_cnt,
    output logic            o_tc
);

    logic [DELW-1:0] r_cnt;
    logic            w_tc;

    assign w_tc  = &r_cnt;
    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/x_micro_recorder.sv
// Capture-side recorder: run-length encodes a sampled bus into DAT/DEL/END
// sequencer commands and writes them through a registered RAM write port.
module x_micro_recorder
    import x_micro_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = MICRO_DW,
    parameter int DELW  = MICRO_DELW
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [DW-1:0]          i_data,
    output logic                   o_busy,
    output logic                   o_wen,
    output logic [MICRO_CMD_W-1:0] o_wcmd,
    output logic [DW-1:0]          o_wdata,
    output logic [AW-1:0]          o_waddr,
    output logic [AW-1:0]          o_len,
    output logic                   o_ovf
);

    rec_state_t      r_state;
    logic            r_start_q;
    logic            r_stop_q;
    logic            r_pend_v;
    logic [AW-1:0]   r_ptr;
    logic [DW-1:0]   r_prev;

    logic            w_start;
    logic            w_stop;
    logic            w_change;
    logic            w_full;
    logic            w_run_nz;
    logic            w_tc;
    logic [DELW-1:0] w_run;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_wr_dat;
    logic            w_wr_del;
    logic            w_need;

    assign w_start  = i_start & ~r_start_q;
    assign w_stop   = i_stop & ~r_stop_q;
    assign w_change = (i_data != r_prev);
    assign w_full   = (r_ptr == AW'(DEPTH - 1));
    assign w_run_nz = (w_run != '0);

    x_micro_rle_cnt #(
        .DELW (DELW)
    ) u_run (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_run),
        .o_tc  (w_tc)
    );

    // A pending DAT only exists while run is 0, so it never competes with a DEL.
    always_comb begin
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_wr_dat  = 1'b0;
        w_wr_del  = 1'b0;
        case (r_state)
            ST_IDLE: w_cnt_clr = w_start;
            ST_REC: begin
                if (w_stop || w_change || w_tc) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
                if (w_stop) begin
                    w_wr_dat = r_pend_v;
                    w_wr_del = !r_pend_v && w_run_nz;
                end else begin
                    w_wr_del = w_change ? w_run_nz : w_tc;
                    w_wr_dat = r_pend_v && !w_wr_del;
                end
            end
            default: ;
        endcase
        w_need = w_wr_dat | w_wr_del;
    end

    // The last-seen value doubles as the pending DAT payload: both are loaded together.
    always_ff @(posedge i_clk) begin
        if ((r_state == ST_IDLE && w_start) ||
            (r_state == ST_REC && !w_stop && w_change)) begin
            r_prev <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_stop_q  <= 1'b0;
            r_pend_v  <= 1'b0;
            r_ptr     <= '0;
            o_busy    <= 1'b0;
            o_wen     <= 1'b0;
            o_wcmd    <= '0;
            o_wdata   <= '0;
            o_waddr   <= '0;
            o_len     <= '0;
            o_ovf     <= 1'b0;
        end else begin
            r_start_q <= i_start;
            r_stop_q  <= i_stop;
            o_wen     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_REC;
                        o_busy   <= 1'b1;
                        r_pend_v <= 1'b1;
                        r_ptr    <= '0;
                        o_ovf    <= 1'b0;
                    end
                end
                ST_REC: begin
                    if (w_need && w_full) begin
                        o_ovf   <= 1'b1;
                        r_state <= ST_FLUSH;
                    end else begin
                        if (w_need) begin
                            o_wen   <= 1'b1;
                            o_waddr <= r_ptr;
                            r_ptr   <= r_ptr + 1'b1;
                        end
                        if (w_wr_dat) begin
                            o_wcmd  <= CMD_DAT;
                            o_wdata <= r_prev;
                        end else if (w_wr_del) begin
                            o_wcmd  <= CMD_DEL;
                            o_wdata <= DW'(w_run);
                        end
                        if (w_stop) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                    if (w_stop) begin
                        r_pend_v <= 1'b0;
                    end else if (w_change) begin
                        r_pend_v <= 1'b1;
                    end else if (w_wr_dat) begin
                        r_pend_v <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    o_wen    <= 1'b1;
                    o_wcmd   <= CMD_END;
                    o_wdata  <= '0;
                    o_waddr  <= r_ptr;
                    o_len    <= r_ptr + 1'b1;
                    r_pend_v <= 1'b0;
                    o_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_micro_recorder.sv
// Scoreboard bench for x_micro_recorder: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares each o_wen cycle.
module tb_x_micro_recorder;
    import x_micro_pkg::*;

    // Small RAM and short delay field keep runs brief; one spare address bit
    // lets o_len show a full 8-entry recording.
    localparam int DEPTH = 8;
    localparam int AW    = 4;
    localparam int DW    = 36;
    localparam int DELW  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   stop;
    logic [DW-1:0]          data;
    logic                   o_busy;
    logic                   o_wen;
    logic [MICRO_CMD_W-1:0] o_wcmd;
    logic [DW-1:0]          o_wdata;
    logic [AW-1:0]          o_waddr;
    logic [AW-1:0]          o_len;
    logic                   o_ovf;

    typedef struct {
        logic [MICRO_CMD_W-1:0] cmd;
        logic [DW-1:0]          dat;
        logic [AW-1:0]          addr;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   streak = 0;
    int   last_streak = 0;

    x_micro_recorder #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .DELW  (DELW)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_stop  (stop),
        .i_data  (data),
        .o_busy  (o_busy),
        .o_wen   (o_wen),
        .o_wcmd  (o_wcmd),
        .o_wdata (o_wdata),
        .o_waddr (o_waddr),
        .o_len   (o_len),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_wen) begin
            streak++;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got cmd=%0h data=%0h addr=%0d, required no write",
                         o_wcmd, o_wdata, o_waddr);
            end else begin
                m_e = q.pop_front();
                if (o_wcmd !== m_e.cmd || o_wdata !== m_e.dat || o_waddr !== m_e.addr) begin
                    n_fail++;
                    $display("FAIL write: got cmd=%0h data=%0h addr=%0d, required cmd=%0h data=%0h addr=%0d",
                             o_wcmd, o_wdata, o_waddr, m_e.cmd, m_e.dat, m_e.addr);
                end
            end
        end else begin
            if (streak != 0) last_streak = streak;
            streak = 0;
        end
    end

    task automatic push(input logic [MICRO_CMD_W-1:0] c, input logic [DW-1:0] d, input int a);
        exp_t e;
        e.cmd  = c;
        e.dat  = d;
        e.addr = AW'(a);
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [DW-1:0] d, input logic st, input logic sp);
        @(posedge clk);
        #1;
        data  = d;
        start = st;
        stop  = sp;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!o_busy) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: o_busy still 1 after 40 cycles, required 0", name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 64'(o_busy), 64'd0);
        check({name, "_wen"}, 64'(o_wen), 64'd0);
        check({name, "_wcmd"}, 64'(o_wcmd), 64'd0);
        check({name, "_wdata"}, 64'(o_wdata), 64'd0);
        check({name, "_waddr"}, 64'(o_waddr), 64'd0);
        check({name, "_len"}, 64'(o_len), 64'd0);
        check({name, "_ovf"}, 64'(o_ovf), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One value per cycle, with a start edge mid-recording that must be ignored.
        push(CMD_DAT, 36'h1, 0);
        push(CMD_DAT, 36'h2, 1);
        push(CMD_DAT, 36'h3, 2);
        push(CMD_DAT, 36'h4, 3);
        push(CMD_END, 36'h0, 4);
        cyc(36'h1, 1'b1, 1'b0);
        cyc(36'h2, 1'b0, 1'b0);
        cyc(36'h3, 1'b1, 1'b0);
        cyc(36'h4, 1'b0, 1'b0);
        cyc(36'h4, 1'b0, 1'b1);
        wait_idle("t2");
        check("t2_len", 64'(o_len), 64'd5);
        check("t2_ovf", 64'(o_ovf), 64'd0);
        @(negedge clk);
        #1;
        check("t2_wen_streak", 64'(last_streak), 64'd5);

        // Start and stop together in IDLE: the recording still begins.
        push(CMD_DAT, 36'h5, 0);
        push(CMD_DEL, 36'h2, 1);
        push(CMD_DAT, 36'h6, 2);
        push(CMD_DAT, 36'h7, 3);
        push(CMD_DEL, 36'h1, 4);
        push(CMD_END, 36'h0, 5);
        cyc(36'h5, 1'b1, 1'b1);
        cyc(36'h5, 1'b0, 1'b0);
        cyc(36'h5, 1'b0, 1'b0);
        cyc(36'h6, 1'b0, 1'b0);
        cyc(36'h7, 1'b0, 1'b0);
        cyc(36'h7, 1'b0, 1'b0);
        cyc(36'h7, 1'b0, 1'b1);
        wait_idle("t3");
        check("t3_len", 64'(o_len), 64'd6);

        // Held for 2^DELW+3 samples: saturated DEL(15) then DEL(2).
        push(CMD_DAT, 36'h55, 0);
        push(CMD_DEL, 36'hF, 1);
        push(CMD_DEL, 36'h2, 2);
        push(CMD_END, 36'h0, 3);
        cyc(36'h55, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) cyc(36'h55, 1'b0, 1'b0);
        cyc(36'h55, 1'b0, 1'b1);
        wait_idle("t4");
        check("t4_len", 64'(o_len), 64'd4);
        check("t4_ovf", 64'(o_ovf), 64'd0);

        // Toggling every cycle fills the RAM: DAT @0..6, END @7, overflow.
        for (int i = 0; i < 7; i++) push(CMD_DAT, DW'(i & 1), i);
        push(CMD_END, 36'h0, 7);
        cyc(36'h0, 1'b1, 1'b0);
        for (int i = 1; i < 20; i++) cyc(DW'(i & 1), 1'b0, 1'b0);
        cyc(36'h0, 1'b0, 1'b1);
        wait_idle("t5");
        check("t5_ovf", 64'(o_ovf), 64'd1);
        check("t5_len", 64'(o_len), 64'd8);
        check("t5_busy", 64'(o_busy), 64'd0);

        // Constant 0xA for 5 samples; the new start clears the sticky overflow.
        push(CMD_DAT, 36'hA, 0);
        push(CMD_DEL, 36'h4, 1);
        push(CMD_END, 36'h0, 2);
        cyc(36'hA, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(36'hA, 1'b0, 1'b0);
        cyc(36'hA, 1'b0, 1'b1);
        wait_idle("t1");
        check("t1_len", 64'(o_len), 64'd3);
        check("t1_ovf", 64'(o_ovf), 64'd0);

        // Reset in the middle of a recording, then record again from address 0.
        push(CMD_DAT, 36'h3, 0);
        cyc(36'h3, 1'b1, 1'b0);
        cyc(36'h3, 1'b0, 1'b0);
        cyc(36'h3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(CMD_DAT, 36'h9, 0);
        push(CMD_DEL, 36'h1, 1);
        push(CMD_END, 36'h0, 2);
        cyc(36'h9, 1'b1, 1'b0);
        cyc(36'h9, 1'b0, 1'b0);
        cyc(36'h9, 1'b0, 1'b1);
        wait_idle("t6");
        check("t6_len", 64'(o_len), 64'd3);
        check("t6_ovf", 64'(o_ovf), 64'd0);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
